// File: rtl/sb_trig_multi.sv
// sb_trig_multi: N-channel single-bin threshold trigger with consecutive-bin, widening,
// multiplicity and required-channel qualification. Define SB_TRIG_HOLDOFF_EN for hold-off.
module sb_trig_multi #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned ADC_WIDTH     = 12,
  parameter int unsigned CONSEC_MAX    = 7,
  parameter int unsigned OVLP_MAX      = 15,
  parameter int unsigned DELAY_MAX     = 15,
  parameter int unsigned HOLDOFF_WIDTH = 16,
  localparam int unsigned DW = $clog2(DELAY_MAX + 1),
  localparam int unsigned MW = $clog2(NCH + 1),
  localparam int unsigned CW = $clog2(CONSEC_MAX + 1),
  localparam int unsigned OW = $clog2(OVLP_MAX + 1)
) (
  input  logic                     CLK120,
  input  logic                     RESET_N,
  input  logic [NCH*ADC_WIDTH-1:0] ADC,
  input  logic [NCH*ADC_WIDTH-1:0] THRES,
  input  logic [NCH-1:0]           CH_ENAB,
  input  logic [NCH*DW-1:0]        CH_DELAY,
  input  logic [CW-1:0]            CONSEC_BINS,
  input  logic [OW-1:0]            COINC_OVLP,
  input  logic [MW-1:0]            MULTIPLICITY,
  input  logic [NCH-1:0]           REQ_MASK,
  input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF,
  output logic                     TRIG,
  output logic [NCH-1:0]           TRIG_PATTERN,
  output logic [31:0]              TRIG_COUNT
);

  localparam logic [DW-1:0] DelayMaxC  = DW'(DELAY_MAX);
  localparam logic [CW-1:0] ConsecMaxC = CW'(CONSEC_MAX);
  localparam logic [OW-1:0] OvlpMaxC   = OW'(OVLP_MAX);

  // Stage 1: input and configuration registers
  logic [ADC_WIDTH-1:0] adc_q   [NCH];
  logic [ADC_WIDTH-1:0] thres_q [NCH];
  logic [DW-1:0]        delay_q [NCH];
  logic [NCH-1:0]       en_q;
  logic [NCH-1:0]       req_q;
  logic [MW-1:0]        mult_q;
  logic [CW-1:0]        consec_q;
  logic [OW-1:0]        ovlp_q;

  // Channel pipeline state
  logic [ADC_WIDTH-1:0] dline_q [NCH][DELAY_MAX];
  logic [ADC_WIDTH-1:0] sel_q   [NCH];
  logic [CONSEC_MAX:0]  hist_q  [NCH];
  logic [OW-1:0]        wcnt_q  [NCH];
  logic [NCH-1:0]       ok_q;
  logic [NCH-1:0]       ok_prev_q;
  logic [NCH-1:0]       edge_q;
  logic [NCH-1:0]       wide_q;

  // Coincidence and trigger state
  logic                 coinc_q;
  logic [NCH-1:0]       pat_q;
  logic                 trig_q;
  logic [NCH-1:0]       trig_pattern_q;
  logic [31:0]          trig_count_q;

  // Clamped configuration; the clamp is elided when the field cannot exceed its maximum.
  logic [CW-1:0] consec_eff;
  logic [OW-1:0] ovlp_eff;
  logic [DW-1:0] delay_eff [NCH];

  if (CONSEC_MAX < (1 << CW) - 1) begin : g_consec_clamp
    assign consec_eff = (consec_q > ConsecMaxC) ? ConsecMaxC : consec_q;
  end else begin : g_consec_pass
    assign consec_eff = consec_q;
  end

  if (OVLP_MAX < (1 << OW) - 1) begin : g_ovlp_clamp
    assign ovlp_eff = (ovlp_q > OvlpMaxC) ? OvlpMaxC : ovlp_q;
  end else begin : g_ovlp_pass
    assign ovlp_eff = ovlp_q;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_delay
    if (DELAY_MAX < (1 << DW) - 1) begin : g_clamp
      assign delay_eff[g] = (delay_q[g] > DelayMaxC) ? DelayMaxC : delay_q[g];
    end else begin : g_pass
      assign delay_eff[g] = delay_q[g];
    end
  end

  // Tap select, threshold compare and consecutive-bin qualification
  logic [ADC_WIDTH-1:0] sel_d [NCH];
  logic [NCH-1:0]       above;
  logic [NCH-1:0]       ok_d;
  logic [CONSEC_MAX:0]  consec_mask;

  always_comb begin
    consec_mask = '0;
    above       = '0;
    ok_d        = '0;
    for (int j = 0; j <= CONSEC_MAX; j++) begin
      consec_mask[j] = (CW'(j) <= consec_eff);
    end
    for (int i = 0; i < NCH; i++) begin
      sel_d[i] = adc_q[i];
      for (int j = 0; j < DELAY_MAX; j++) begin
        if (delay_eff[i] == DW'(j + 1)) sel_d[i] = dline_q[i][j];
      end
      above[i] = sel_q[i] > thres_q[i];
      // Unused history bits beyond the requested run length are masked to one.
      ok_d[i]  = en_q[i] & (&(hist_q[i] | ~consec_mask));
    end
  end

  // Multiplicity over non-required channels plus all-required check
  logic [MW-1:0] pop;
  logic          coinc_d;
  logic          trig_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + MW'(wide_q[i] & en_q[i] & ~req_q[i]);
    end
    coinc_d = (mult_q != '0) && (pop >= mult_q) && (&(wide_q | ~(req_q & en_q)));
  end

`ifdef SB_TRIG_HOLDOFF_EN
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [HOLDOFF_WIDTH-1:0] hold_q;

  always_comb begin
    trig_d = coinc_q & ~trig_q & (hold_q == '0);
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      holdoff_q <= '0;
      hold_q    <= '0;
    end else begin
      holdoff_q <= HOLDOFF;
      if (trig_d) begin
        hold_q <= holdoff_q;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLDOFF_WIDTH'(1);
      end
    end
  end
`else
  logic holdoff_unused;
  assign holdoff_unused = ^HOLDOFF;

  always_comb begin
    trig_d = coinc_q & ~trig_q;
  end
`endif

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        adc_q[i]   <= '0;
        thres_q[i] <= '0;
        delay_q[i] <= '0;
        sel_q[i]   <= '0;
        hist_q[i]  <= '0;
        wcnt_q[i]  <= '0;
        for (int j = 0; j < DELAY_MAX; j++) dline_q[i][j] <= '0;
      end
      en_q      <= '0;
      req_q     <= '0;
      mult_q    <= '0;
      consec_q  <= '0;
      ovlp_q    <= '0;
      ok_q      <= '0;
      ok_prev_q <= '0;
      edge_q    <= '0;
      wide_q    <= '0;
    end else begin
      en_q     <= CH_ENAB;
      req_q    <= REQ_MASK;
      mult_q   <= MULTIPLICITY;
      consec_q <= CONSEC_BINS;
      ovlp_q   <= COINC_OVLP;
      for (int i = 0; i < NCH; i++) begin
        adc_q[i]      <= ADC[i*ADC_WIDTH +: ADC_WIDTH];
        thres_q[i]    <= THRES[i*ADC_WIDTH +: ADC_WIDTH];
        delay_q[i]    <= CH_DELAY[i*DW +: DW];
        dline_q[i][0] <= adc_q[i];
        for (int j = 1; j < DELAY_MAX; j++) dline_q[i][j] <= dline_q[i][j-1];
        sel_q[i]  <= sel_d[i];
        hist_q[i] <= {hist_q[i][CONSEC_MAX-1:0], above[i]};
        // A fresh edge reloads the window, so a retrigger extends it.
        if (edge_q[i]) begin
          wcnt_q[i] <= ovlp_eff;
          wide_q[i] <= 1'b1;
        end else if (wcnt_q[i] != '0) begin
          wcnt_q[i] <= wcnt_q[i] - OW'(1);
          wide_q[i] <= 1'b1;
        end else begin
          wide_q[i] <= 1'b0;
        end
      end
      ok_q      <= ok_d;
      ok_prev_q <= ok_q;
      edge_q    <= ok_q & ~ok_prev_q;
    end
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      coinc_q        <= 1'b0;
      pat_q          <= '0;
      trig_q         <= 1'b0;
      trig_pattern_q <= '0;
      trig_count_q   <= '0;
    end else begin
      coinc_q <= coinc_d;
      pat_q   <= wide_q & en_q;
      trig_q  <= trig_d;
      if (trig_d) begin
        trig_pattern_q <= pat_q;
        trig_count_q   <= trig_count_q + 32'd1;
      end
    end
  end

  assign TRIG         = trig_q;
  assign TRIG_PATTERN = trig_pattern_q;
  assign TRIG_COUNT   = trig_count_q;

endmodule

// File: tb/tb_sb_trig_multi.sv
// Bench for sb_trig_multi: directed vector table, hand sequences for reset, hold-off and
// counter wrap, and randomized runs checked against an event-level reference model.
module tb_sb_trig_multi;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int DW  = 4;
  localparam int MW  = 3;
  localparam int CW  = 3;
  localparam int OW  = 4;
  localparam int HW  = 16;
  localparam int LEN = 256;

`ifdef SB_TRIG_HOLDOFF_EN
  localparam int HoGap = 25;
  localparam int HoN   = 3;
`else
  localparam int HoGap = 5;
  localparam int HoN   = 11;
`endif

  logic              CLK120 = 1'b0;
  logic              RESET_N;
  logic [NCH*AW-1:0] ADC;
  logic [NCH*AW-1:0] THRES;
  logic [NCH-1:0]    CH_ENAB;
  logic [NCH*DW-1:0] CH_DELAY;
  logic [CW-1:0]     CONSEC_BINS;
  logic [OW-1:0]     COINC_OVLP;
  logic [MW-1:0]     MULTIPLICITY;
  logic [NCH-1:0]    REQ_MASK;
  logic [HW-1:0]     HOLDOFF;
  logic              TRIG;
  logic [NCH-1:0]    TRIG_PATTERN;
  logic [31:0]       TRIG_COUNT;

  sb_trig_multi #(
    .NCH(NCH), .ADC_WIDTH(AW), .CONSEC_MAX(7), .OVLP_MAX(15), .DELAY_MAX(15),
    .HOLDOFF_WIDTH(HW)
  ) dut (
    .CLK120(CLK120), .RESET_N(RESET_N), .ADC(ADC), .THRES(THRES), .CH_ENAB(CH_ENAB),
    .CH_DELAY(CH_DELAY), .CONSEC_BINS(CONSEC_BINS), .COINC_OVLP(COINC_OVLP),
    .MULTIPLICITY(MULTIPLICITY), .REQ_MASK(REQ_MASK), .HOLDOFF(HOLDOFF), .TRIG(TRIG),
    .TRIG_PATTERN(TRIG_PATTERN), .TRIG_COUNT(TRIG_COUNT)
  );

  always #5 CLK120 = ~CLK120;

  int errors = 0;
  int checks = 0;

  int cfg_thr [NCH];
  int cfg_dly [NCH];
  logic [NCH-1:0] cfg_en, cfg_req;
  int cfg_mult, cfg_c, cfg_o, cfg_h;

  int stim [NCH][LEN];
  bit             obs_trig [LEN];
  logic [NCH-1:0] obs_pat  [LEN];
  logic [31:0]    obs_cnt  [LEN];
  bit             exp_trig [LEN];
  logic [NCH-1:0] exp_pat  [LEN];
  logic [31:0]    exp_cnt  [LEN];

  typedef struct {
    int amp; logic [3:0] en; logic [3:0] req; int mult; int c; int o; int d1;
    int s0; int s1; int s2; int s3; int ln; int exp_n; int exp_t; logic [3:0] exp_pat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NCH; i++) begin
      THRES[i*AW +: AW]    = AW'(cfg_thr[i]);
      CH_DELAY[i*DW +: DW] = DW'(cfg_dly[i]);
    end
    CH_ENAB      = cfg_en;
    REQ_MASK     = cfg_req;
    MULTIPLICITY = MW'(cfg_mult);
    CONSEC_BINS  = CW'(cfg_c);
    COINC_OVLP   = OW'(cfg_o);
    HOLDOFF      = HW'(cfg_h);
  endtask

  task automatic do_reset();
    ADC     = '0;
    RESET_N = 1'b0;
    apply_cfg();
    repeat (2) @(negedge CLK120);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK120);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NCH; i++)
      for (int t = 0; t < LEN; t++) stim[i][t] = 0;
  endtask

  task automatic set_pulse(input int ch, input int st, input int ln, input int amp);
    if (st > 0)
      for (int t = st; t < st + ln; t++) stim[ch][t] = amp;
  endtask

  // Entered just after a falling edge; cycle t is the rising edge that registers stim[*][t].
  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < NCH; i++) ADC[i*AW +: AW] = AW'(stim[i][t]);
      @(posedge CLK120);
      @(negedge CLK120);
      obs_trig[t] = TRIG;
      obs_pat[t]  = TRIG_PATTERN;
      obs_cnt[t]  = TRIG_COUNT;
    end
    ADC = '0;
  endtask

  // Reference model: trigger events derived directly from sample streams.
  function automatic bit m_above(input int ch, input int s);
    if (s < 0) return 1'b0;
    return stim[ch][s] > cfg_thr[ch];
  endfunction

  function automatic bit m_ok(input int ch, input int s);
    if (!cfg_en[ch]) return 1'b0;
    for (int j = 0; j <= cfg_c; j++) if (!m_above(ch, s - j)) return 1'b0;
    return 1'b1;
  endfunction

  // Channel window covers trigger times [s+d+7, s+d+7+O] for every rising OK at sample s.
  function automatic bit m_win(input int ch, input int t);
    for (int s = 0; s <= t; s++) begin
      int e;
      e = s + cfg_dly[ch] + 7;
      if (t >= e && t <= e + cfg_o && m_ok(ch, s) && !m_ok(ch, s - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_run(input int n);
    int last, cnt;
    bit prev;
    logic [NCH-1:0] held;
    last = -100000; cnt = 0; prev = 1'b0; held = '0;
    for (int t = 0; t < n; t++) begin
      logic [NCH-1:0] w;
      int nr;
      bit co, tr;
      nr = 0;
      co = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        w[ch] = cfg_en[ch] && m_win(ch, t);
        if (w[ch] && !cfg_req[ch]) nr++;
        if (cfg_en[ch] && cfg_req[ch] && !w[ch]) co = 1'b0;
      end
      if (cfg_mult == 0 || nr < cfg_mult) co = 1'b0;
      tr = co && !prev;
`ifdef SB_TRIG_HOLDOFF_EN
      if (t - last <= cfg_h) tr = 1'b0;
`endif
      if (tr) begin
        last = t;
        held = w;
        cnt++;
      end
      exp_trig[t] = tr;
      exp_pat[t]  = held;
      exp_cnt[t]  = 32'(cnt);
      prev = tr;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, first_t;
    int left [NCH];

    //          amp  en       req      mu c  o  d1 s0  s1  s2 s3  ln n  t   pat
    vecs[0]  = '{101, 4'b0001, 4'b0000, 1, 0, 0, 0, 10, 0,  0, 0,  1, 1, 17, 4'b0001};
    vecs[1]  = '{100, 4'b0001, 4'b0000, 1, 0, 0, 0, 10, 0,  0, 0,  1, 0, -1, 4'b0000};
    vecs[2]  = '{101, 4'b0001, 4'b0000, 1, 2, 0, 0, 10, 0,  0, 0,  2, 0, -1, 4'b0000};
    vecs[3]  = '{101, 4'b0001, 4'b0000, 1, 2, 0, 0, 10, 0,  0, 0,  3, 1, 19, 4'b0001};
    vecs[4]  = '{101, 4'b0001, 4'b0000, 1, 2, 0, 0, 10, 0,  0, 0, 10, 1, 19, 4'b0001};
    vecs[5]  = '{101, 4'b0011, 4'b0000, 2, 0, 3, 0, 10, 13, 0, 0,  1, 1, 20, 4'b0011};
    vecs[6]  = '{101, 4'b0011, 4'b0000, 2, 0, 3, 0, 10, 14, 0, 0,  1, 0, -1, 4'b0000};
    vecs[7]  = '{101, 4'b0011, 4'b0000, 2, 0, 3, 4, 14, 10, 0, 0,  1, 2, 21, 4'b0011};
    vecs[8]  = '{101, 4'b1011, 4'b1000, 2, 0, 1, 0, 10, 10, 0, 0,  1, 0, -1, 4'b0000};
    vecs[9]  = '{101, 4'b1011, 4'b1000, 2, 0, 1, 0, 10, 10, 0, 10, 1, 1, 17, 4'b1011};
    vecs[10] = '{101, 4'b1111, 4'b0000, 0, 0, 0, 0, 10, 10, 10, 10, 1, 0, -1, 4'b0000};
    vecs[11] = '{101, 4'b0011, 4'b0001, 1, 0, 0, 0, 10, 10, 0, 0,  1, 1, 17, 4'b0011};
    vecs[12] = '{101, 4'b0011, 4'b0001, 1, 0, 0, 0, 0,  10, 0, 0,  1, 0, -1, 4'b0000};
    vecs[13] = '{101, 4'b0001, 4'b0000, 1, 0, 0, 0, 10, 0,  0, 0,  8, 1, 17, 4'b0001};
    vecs[14] = '{101, 4'b0010, 4'b0000, 1, 0, 0, 0, 10, 0,  0, 0,  1, 0, -1, 4'b0000};
    vecs[15] = '{101, 4'b0011, 4'b0000, 2, 0, 0, 0, 10, 0,  0, 0,  1, 0, -1, 4'b0000};

    for (int i = 0; i < NCH; i++) begin
      cfg_thr[i] = 100;
      cfg_dly[i] = 0;
    end
    cfg_en = 4'b0001; cfg_req = '0; cfg_mult = 1; cfg_c = 0; cfg_o = 0; cfg_h = 0;
    do_reset();
    check("reset TRIG", 64'(TRIG), 64'd0);
    check("reset TRIG_PATTERN", 64'(TRIG_PATTERN), 64'd0);
    check("reset TRIG_COUNT", 64'(TRIG_COUNT), 64'd0);

    for (int v = 0; v < NV; v++) begin
      clear_stim();
      cfg_dly[1] = vecs[v].d1;
      cfg_en = vecs[v].en; cfg_req = vecs[v].req; cfg_mult = vecs[v].mult;
      cfg_c = vecs[v].c; cfg_o = vecs[v].o; cfg_h = 0;
      set_pulse(0, vecs[v].s0, vecs[v].ln, vecs[v].amp);
      set_pulse(1, vecs[v].s1, vecs[v].ln, vecs[v].amp);
      set_pulse(2, vecs[v].s2, vecs[v].ln, vecs[v].amp);
      set_pulse(3, vecs[v].s3, vecs[v].ln, vecs[v].amp);
      do_reset();
      run(50);
      n = 0; first_t = -1;
      for (int t = 0; t < 50; t++) if (obs_trig[t]) begin
        if (n == 0) first_t = t;
        n++;
      end
      check($sformatf("vec%0d trig count", v), 64'(n), 64'(vecs[v].exp_n));
      check($sformatf("vec%0d first trig cycle", v), 64'(first_t), 64'(vecs[v].exp_t));
      check($sformatf("vec%0d TRIG_PATTERN", v), 64'(obs_pat[49]), 64'(vecs[v].exp_pat));
      check($sformatf("vec%0d TRIG_COUNT", v), 64'(obs_cnt[49]), 64'(vecs[v].exp_n));
    end
    cfg_dly[1] = 0;

    // Asynchronous reset while TRIG is high and the window is still open.
    clear_stim();
    cfg_en = 4'b0001; cfg_req = '0; cfg_mult = 1; cfg_c = 0; cfg_o = 15; cfg_h = 0;
    set_pulse(0, 5, 1, 101);
    do_reset();
    run(13);
    check("pre-reset TRIG at k+7", 64'(obs_trig[12]), 64'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("async reset TRIG", 64'(TRIG), 64'd0);
    check("async reset TRIG_COUNT", 64'(TRIG_COUNT), 64'd0);
    check("async reset TRIG_PATTERN", 64'(TRIG_PATTERN), 64'd0);
    @(negedge CLK120);
    RESET_N = 1'b1;
    clear_stim();
    run(30);
    n = 0;
    for (int t = 0; t < 30; t++) n += int'(obs_trig[t]);
    check("post-reset no stale trigger", 64'(n), 64'd0);
    check("post-reset TRIG_COUNT", 64'(obs_cnt[29]), 64'd0);

    // Hold-off: ch0 pulse every 5 clocks.
    clear_stim();
    cfg_o = 0; cfg_h = 20;
    for (int j = 0; j <= 10; j++) set_pulse(0, 10 + 5 * j, 1, 101);
    do_reset();
    run(80);
    n = 0;
    for (int t = 0; t < 80; t++) if (obs_trig[t]) begin
      check($sformatf("holdoff trig %0d cycle", n), 64'(t), 64'(17 + n * HoGap));
      n++;
    end
    check("holdoff trig count", 64'(n), 64'(HoN));

    // Counter wrap from a forced all-ones value.
    clear_stim();
    cfg_h = 0;
    set_pulse(0, 5, 1, 101);
    do_reset();
    force dut.trig_count_q = 32'hFFFF_FFFF;
    @(negedge CLK120);
    release dut.trig_count_q;
    #1;
    check("forced TRIG_COUNT", 64'(TRIG_COUNT), 64'hFFFF_FFFF);
    run(20);
    check("wrap trigger seen", 64'(obs_trig[12]), 64'd1);
    check("TRIG_COUNT wrap", 64'(obs_cnt[19]), 64'd0);

    // Randomized configurations against the reference model.
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      for (int i = 0; i < NCH; i++) begin
        cfg_thr[i] = $urandom_range(50, 3000);
        cfg_dly[i] = $urandom_range(0, 15);
        cfg_en[i]  = ($urandom_range(0, 99) < 80);
        cfg_req[i] = ($urandom_range(0, 99) < 20);
        left[i]    = 0;
      end
      cfg_mult = $urandom_range(0, 3);
      cfg_c    = $urandom_range(0, 2);
      cfg_o    = $urandom_range(0, 6);
      cfg_h    = $urandom_range(0, 12);
      for (int t = 0; t < LEN - 40; t++) begin
        for (int i = 0; i < NCH; i++) begin
          if (left[i] == 0 && $urandom_range(0, 99) < 12) left[i] = $urandom_range(1, 4);
          if (left[i] > 0) begin
            stim[i][t] = cfg_thr[i] + 1 + $urandom_range(0, 50);
            left[i]--;
          end else begin
            stim[i][t] = $urandom_range(0, cfg_thr[i]);
          end
        end
      end
      do_reset();
      run(LEN);
      model_run(LEN);
      for (int t = 0; t < LEN; t++) begin
        check($sformatf("rand%0d TRIG t=%0d", r, t), 64'(obs_trig[t]), 64'(exp_trig[t]));
        check($sformatf("rand%0d pattern/count t=%0d", r, t),
              {28'd0, obs_pat[t], obs_cnt[t]}, {28'd0, exp_pat[t], exp_cnt[t]});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
